// File: rtl/di_fifo_terminal.sv
// DI-bus streaming terminal: ingress FIFO (fabric -> host reads) with FWFT output register,
// egress FIFO (host writes -> fabric), level/control/overflow registers. Define DI_FIFO_TIMEOUT_EN for read-stall timeout.
module di_fifo_terminal #(
    parameter logic [15:0] TERM_ADDR      = 16'h0010,
    parameter int unsigned DEPTH_LOG2     = 9,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        ifclk,
    input  logic        resetb,
    input  logic [15:0] di_term_addr,
    input  logic [31:0] di_reg_addr,
    input  logic        di_read_req,
    input  logic        di_read,
    input  logic        di_write,
    input  logic [15:0] di_reg_datai,
    output logic [15:0] di_reg_datao,
    output logic        di_read_rdy,
    output logic        di_write_rdy,
    output logic [15:0] di_transfer_status,
    input  logic        src_we,
    input  logic [15:0] src_data,
    output logic [15:0] sink_data,
    output logic        sink_valid,
    input  logic        sink_ready
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned LW    = DEPTH_LOG2 + 1;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [LW-1:0]         lvl_t;

    localparam lvl_t FULL_LVL = lvl_t'(DEPTH);

    typedef enum logic [2:0] {
        REG_DATA,
        REG_ING_LVL,
        REG_EGR_LVL,
        REG_CTRL,
        REG_OVF,
        REG_NONE
    } reg_sel_e;

    if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 15 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("di_fifo_terminal: unsupported parameter value");
    end

    // Reset asserts asynchronously, deasserts two ifclk edges after resetb rises.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) rst_sync_q <= '0;
        else         rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    logic     sel;
    reg_sel_e reg_sel;

    assign sel = (di_term_addr == TERM_ADDR);

    always_comb begin
        case (di_reg_addr)
            32'd0:   reg_sel = REG_DATA;
            32'd1:   reg_sel = REG_ING_LVL;
            32'd2:   reg_sel = REG_EGR_LVL;
            32'd3:   reg_sel = REG_CTRL;
            32'd4:   reg_sel = REG_OVF;
            default: reg_sel = REG_NONE;
        endcase
    end

    logic [15:0] ing_mem_q [DEPTH];
    ptr_t        ing_wr_q, ing_wr_d, ing_rd_q, ing_rd_d;
    lvl_t        ing_cnt_q, ing_cnt_d;
    logic [15:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;

    logic [15:0] egr_mem_q [DEPTH];
    ptr_t        egr_wr_q, egr_wr_d, egr_rd_q, egr_rd_d;
    lvl_t        egr_cnt_q, egr_cnt_d;

    logic        ing_flush_q, ing_flush_d, egr_flush_q, egr_flush_d;
    logic [15:0] ovf_cnt_q, ovf_cnt_d;
    logic        ovf_sticky_q, ovf_sticky_d;
    logic [15:0] reg_data_q, reg_data_d;
    logic        armed_q, armed_d;

    lvl_t ing_level;
    logic ing_full, ing_empty, egr_full, egr_empty;
    logic host_read_ok, ing_pop, ing_push, ing_load, ing_ovf;
    logic egr_push, egr_pop, ctrl_wr;
    logic tmo_fire, tmo_stat;

    assign ing_level = ing_cnt_q + lvl_t'(out_valid_q);
    assign ing_full  = (ing_level == FULL_LVL);
    assign ing_empty = (ing_level == '0);
    assign egr_full  = (egr_cnt_q == FULL_LVL);
    assign egr_empty = (egr_cnt_q == '0);

    always_comb begin
        if (!rst_n || !sel)          di_read_rdy = 1'b0;
        else if (reg_sel == REG_DATA) di_read_rdy = tmo_fire || (out_valid_q && !di_read_req);
        else                          di_read_rdy = armed_q && !di_read_req;
    end

    assign di_write_rdy = rst_n && sel && (reg_sel != REG_DATA || !egr_full);
    assign host_read_ok = sel && di_read && di_read_rdy;
    assign ing_pop      = host_read_ok && (reg_sel == REG_DATA) && !tmo_fire;
    assign egr_push     = sel && di_write && di_write_rdy && (reg_sel == REG_DATA) && !egr_flush_q;
    assign ctrl_wr      = sel && di_write && (reg_sel == REG_CTRL);

    assign sink_valid = !egr_empty && !egr_flush_q;
    assign sink_data  = sink_valid ? egr_mem_q[egr_rd_q] : '0;
    assign egr_pop    = sink_valid && sink_ready;

    assign di_reg_datao       = (reg_sel == REG_DATA) ? (tmo_fire ? 16'hDEAD : out_data_q) : reg_data_q;
    assign di_transfer_status = {13'b0, tmo_stat, 1'b0, ovf_sticky_q};

    // A pop at full frees a slot in the same cycle, so a coincident push is accepted.
    always_comb begin
        ing_wr_d    = ing_wr_q;
        ing_rd_d    = ing_rd_q;
        ing_cnt_d   = ing_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        ing_push    = 1'b0;
        ing_load    = 1'b0;
        ing_ovf     = 1'b0;
        if (ing_flush_q) begin
            ing_wr_d    = '0;
            ing_rd_d    = '0;
            ing_cnt_d   = '0;
            out_data_d  = '0;
            out_valid_d = 1'b0;
        end else begin
            ing_push = src_we && (!ing_full || ing_pop);
            ing_ovf  = src_we && ing_full && !ing_pop;
            ing_load = (!out_valid_q || ing_pop) && (ing_cnt_q != '0);
            if (ing_load) begin
                out_data_d  = ing_mem_q[ing_rd_q];
                out_valid_d = 1'b1;
                ing_rd_d    = ing_rd_q + 1'b1;
            end else if (ing_pop) begin
                out_valid_d = 1'b0;
            end
            if (ing_push) ing_wr_d = ing_wr_q + 1'b1;
            ing_cnt_d = ing_cnt_q + lvl_t'(ing_push) - lvl_t'(ing_load);
        end
    end

    always_comb begin
        egr_wr_d  = egr_wr_q;
        egr_rd_d  = egr_rd_q;
        egr_cnt_d = egr_cnt_q;
        if (egr_flush_q) begin
            egr_wr_d  = '0;
            egr_rd_d  = '0;
            egr_cnt_d = '0;
        end else begin
            if (egr_push) egr_wr_d = egr_wr_q + 1'b1;
            if (egr_pop)  egr_rd_d = egr_rd_q + 1'b1;
            egr_cnt_d = egr_cnt_q + lvl_t'(egr_push) - lvl_t'(egr_pop);
        end
    end

    always_comb begin
        ing_flush_d  = ctrl_wr && di_reg_datai[0];
        egr_flush_d  = ctrl_wr && di_reg_datai[1];
        ovf_cnt_d    = ovf_cnt_q;
        ovf_sticky_d = ovf_sticky_q;
        armed_d      = sel && (armed_q || di_read_req);
        if (ctrl_wr && di_reg_datai[2]) begin
            ovf_cnt_d    = '0;
            ovf_sticky_d = 1'b0;
        end else if (ing_ovf) begin
            ovf_sticky_d = 1'b1;
            if (ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 1'b1;
        end
        case (reg_sel)
            REG_ING_LVL: reg_data_d = 16'(ing_level);
            REG_EGR_LVL: reg_data_d = 16'(egr_cnt_q);
            REG_CTRL:    reg_data_d = {13'b0, ovf_sticky_q, egr_empty, ing_empty};
            REG_OVF:     reg_data_d = ovf_cnt_q;
            default:     reg_data_d = '0;
        endcase
    end

`ifdef DI_FIFO_TIMEOUT_EN
    localparam int unsigned SW = $clog2(TIMEOUT_CYCLES);
    typedef logic [SW-1:0] stall_t;

    stall_t stall_q, stall_d;
    logic   fire_q, fire_d, tstat_q, tstat_d;

    always_comb begin
        stall_d = stall_q;
        fire_d  = fire_q;
        tstat_d = tstat_q;
        if (sel && di_read_req) tstat_d = 1'b0;
        if (!sel || host_read_ok) begin
            stall_d = '0;
            fire_d  = 1'b0;
        end else if (!fire_q && armed_q && reg_sel == REG_DATA && di_read && !di_read_rdy) begin
            if (stall_q == stall_t'(TIMEOUT_CYCLES - 1)) begin
                stall_d = '0;
                fire_d  = 1'b1;
                tstat_d = 1'b1;
            end else begin
                stall_d = stall_q + 1'b1;
            end
        end
    end

    always_ff @(posedge ifclk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            fire_q  <= 1'b0;
            tstat_q <= 1'b0;
        end else begin
            stall_q <= stall_d;
            fire_q  <= fire_d;
            tstat_q <= tstat_d;
        end
    end

    assign tmo_fire = fire_q;
    assign tmo_stat = tstat_q;
`else
    assign tmo_fire = 1'b0;
    assign tmo_stat = 1'b0;
`endif

    always_ff @(posedge ifclk) begin
        if (ing_push) ing_mem_q[ing_wr_q] <= src_data;
        if (egr_push) egr_mem_q[egr_wr_q] <= di_reg_datai;
    end

    always_ff @(posedge ifclk or negedge rst_n) begin
        if (!rst_n) begin
            ing_wr_q     <= '0;
            ing_rd_q     <= '0;
            ing_cnt_q    <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            egr_wr_q     <= '0;
            egr_rd_q     <= '0;
            egr_cnt_q    <= '0;
            ing_flush_q  <= 1'b0;
            egr_flush_q  <= 1'b0;
            ovf_cnt_q    <= '0;
            ovf_sticky_q <= 1'b0;
            reg_data_q   <= '0;
            armed_q      <= 1'b0;
        end else begin
            ing_wr_q     <= ing_wr_d;
            ing_rd_q     <= ing_rd_d;
            ing_cnt_q    <= ing_cnt_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            egr_wr_q     <= egr_wr_d;
            egr_rd_q     <= egr_rd_d;
            egr_cnt_q    <= egr_cnt_d;
            ing_flush_q  <= ing_flush_d;
            egr_flush_q  <= egr_flush_d;
            ovf_cnt_q    <= ovf_cnt_d;
            ovf_sticky_q <= ovf_sticky_d;
            reg_data_q   <= reg_data_d;
            armed_q      <= armed_d;
        end
    end

endmodule

// File: doc/di_fifo_terminal.md
Name: di_fifo_terminal

Overview:
- Device-interface (DI) terminal sitting directly downstream of HostInterface, alongside the other terminals on the shared di_* bus.
- Gives the host a streaming data port backed by two FIFOs:
  - ingress FIFO: fabric → host reads.
  - egress FIFO: host writes → fabric.
- Also exposes level, control and overflow registers.
- Top-level mux selects this block's di_reg_datao/di_read_rdy/di_write_rdy/di_transfer_status when di_term_addr == TERM_ADDR.

Parameters:
TERM_ADDR, 16'h0010, terminal address this block answers to
DEPTH_LOG2, 9, log2 of each FIFO depth (512 words)
TIMEOUT_CYCLES, 1024, read-stall limit (used only with optional feature)

Ports:
ifclk  in  1  clock, all logic on rising edge
resetb  in  1  reset, asynchronous, active-low
di_term_addr  in  16  selected terminal
di_reg_addr  in  32  register address within terminal
di_read_req  in  1  one-cycle pulse preceding a read transaction
di_read  in  1  read strobe, word consumed when di_read_rdy high
di_write  in  1  write strobe, word taken when di_write_rdy high
di_reg_datai  in  16  write data
di_reg_datao  out  16  read data (registered)
di_read_rdy  out  1  read data valid
di_write_rdy  out  1  write can be accepted
di_transfer_status  out  16  {13'b0, timeout, 1'b0, ovf_sticky}
src_we  in  1  fabric push into ingress (no backpressure)
src_data  in  16  fabric ingress data
sink_data  out  16  egress head word
sink_valid  out  1  egress non-empty
sink_ready  in  1  fabric pops egress when sink_valid && sink_ready

Behaviour:
- sel = (di_term_addr == TERM_ADDR).
- When sel=0:
  - di_read_rdy=0, di_write_rdy=0.
  - Internal state is kept.
  - sink_* and src_we operate regardless of sel.
- Register map by di_reg_addr:
  - 0 DATA: R pops ingress; W pushes egress.
  - 1 ING_LEVEL: R only; ingress words including the output register.
  - 2 EGR_LEVEL: R only.
  - 3 CTRL:
    - W: bit0 flush ingress, bit1 flush egress, bit2 clear ovf_sticky and OVF_COUNT.
    - R: {13'b0, ovf_sticky, egr_empty, ing_empty}.
  - 4 OVF_COUNT: R only; 16-bit counter, saturates at FFFF.
  - ≥5: read 16'h0000 with read_rdy=1; writes accepted and ignored.
- Ingress is FWFT with an output register.
  - DATA read: di_read_rdy = sel && out_valid && !di_read_req.
  - On di_read && di_read_rdy, the output register reloads from the FIFO in the same cycle if the FIFO is non-empty.
  - Result: back-to-back reads at one word/cycle.
  - Empty: di_read_rdy=0 and the host stalls.
- Non-DATA reads:
  - di_reg_datao registered one cycle after di_read_req.
  - di_read_rdy=1 from the cycle after di_read_req.
- Ingress push: src_we when level==depth drops the word, increments OVF_COUNT (saturating) and sets ovf_sticky.
  - Push and pop in the same cycle at full: the push is accepted with no overflow.
- Egress: di_write_rdy = sel && (reg_addr!=0 || !egr_full).
  - di_write while di_write_rdy=0: word dropped, no state change.
  - Host push and sink pop in the same cycle are both honoured.
  - Egress level is unchanged by a simultaneous push and pop.
- Flush:
  - Takes effect the cycle after the CTRL write; empties the FIFO including the output register.
  - src_we in the flush cycle is dropped without counting overflow.
  - Pointers wrap modulo 2^DEPTH_LOG2.
  - Level counters are DEPTH_LOG2+1 bits, zero-extended to 16.
- Reset (async assert, release sync to ifclk):
  - All outputs 0, FIFOs empty, counters and ovf_sticky cleared.
  - Reset mid-transaction aborts it; no partial word appears on sink_data.

Optional Feature:
DI_FIFO_TIMEOUT_EN
- Defined:
  - A stall counter runs while sel && DATA read pending && di_read_rdy=0.
  - At TIMEOUT_CYCLES it forces di_reg_datao=16'hDEAD and di_read_rdy=1 for one word, with no pop.
  - Sets the timeout status bit; cleared by the next di_read_req.
  - The counter resets on any successful read or deselect.
- Undefined:
  - No counter; the host stalls indefinitely on an empty ingress.
  - Status bit2 is always 0.

Test Plan:
- Reset, select terminal, read addr 1 and 3 → ING_LEVEL 0x0000; CTRL 0x0003.
- Push 4 words 0x1000..0x1003 via src_we, 4-word DATA read → datao 0x1000..0x1003 on consecutive cycles, read_rdy continuous, then ING_LEVEL=0.
- Fill ingress to 512, push 3 more → OVF_COUNT=3, status=0x0001; then write CTRL=0x0004 → count 0, status 0.
- Host writes 600 words, sink_ready=0 → write_rdy drops after word 512, EGR_LEVEL=512; raise sink_ready → sink_data order 0..511 preserved.
- At full ingress, src_we and di_read together → level stays 512, no overflow.
- With DI_FIFO_TIMEOUT_EN, empty ingress, DATA read → after 1024 cycles datao=0xDEAD, read_rdy=1, status=0x0004; without the macro, read_rdy stays 0.
